// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode encoding, datapath width
// and small bit-manipulation helpers used by the shifter.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_EQ   = 4'd10,
        OP_NE   = 4'd11,
        OP_LT   = 4'd12,
        OP_GE   = 4'd13,
        OP_LTU  = 4'd14,
        OP_GEU  = 4'd15
    } alu_op_e;

    // Left shifts reuse the right-shift network by mirroring the word.
    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_compare.sv
// Shared magnitude comparator: eq, signed-lt and unsigned-lt from one 33-bit subtract.
// Combinational, no latency; no flow control.
module alu_compare
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            eq,
    output logic            lt_signed,
    output logic            lt_unsigned
);

    logic [XLEN:0] diff;

    // The extra top bit of the zero-extended subtract is the unsigned borrow.
    assign diff        = {1'b0, a} - {1'b0, b};
    assign eq          = (diff[XLEN-1:0] == '0);
    assign lt_unsigned = diff[XLEN];

    // Differing signs decide the signed order directly; otherwise the low-word
    // difference cannot overflow and its sign bit is the answer.
    assign lt_signed = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU: opcode mux, barrel shifter and output registers.
// Fixed 1-cycle latency, one op per cycle, no backpressure (outputs update every edge).
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InA,
    input  logic [XLEN-1:0] InB,
    input  logic [3:0]      Op,
    output logic [XLEN-1:0] Result,
    output logic            Compare
);

    alu_op_e         op;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic [SHAMT_W-1:0] shamt;
    logic            shift_left;
    logic            fill;
    logic [XLEN-1:0] stg [0:SHAMT_W];
    logic [XLEN-1:0] shr_out;
    logic [XLEN-1:0] res_d;
    logic            cmp_d;

    assign op = alu_op_e'(Op);

    alu_compare u_cmp (
        .a           (InA),
        .b           (InB),
        .eq          (eq),
        .lt_signed   (lt_s),
        .lt_unsigned (lt_u)
    );

    // Single right-shift network; SLL mirrors input and output around it.
    assign shamt      = InB[SHAMT_W-1:0];
    assign shift_left = (op == OP_SLL);
    assign fill       = (op == OP_SRA) & InA[XLEN-1];
    assign stg[0]     = shift_left ? bit_reverse(InA) : InA;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_shift
        assign stg[i+1] = shamt[i] ? {{(1 << i){fill}}, stg[i][XLEN-1:(1 << i)]}
                                   : stg[i];
    end

    assign shr_out = shift_left ? bit_reverse(stg[SHAMT_W]) : stg[SHAMT_W];

    always_comb begin
        res_d = '0;
        cmp_d = 1'b0;
        case (op)
            OP_ADD:  res_d = InA + InB;
            OP_SUB:  res_d = InA - InB;
            OP_AND:  res_d = InA & InB;
            OP_OR:   res_d = InA | InB;
            OP_XOR:  res_d = InA ^ InB;
            OP_SLT:  cmp_d = lt_s;
            OP_SLTU: cmp_d = lt_u;
            OP_SLL,
            OP_SRL,
            OP_SRA:  res_d = shr_out;
            OP_EQ:   cmp_d = eq;
            OP_NE:   cmp_d = ~eq;
            OP_LT:   cmp_d = lt_s;
            OP_GE:   cmp_d = ~lt_s;
            OP_LTU:  cmp_d = lt_u;
            OP_GEU:  cmp_d = ~lt_u;
            default: begin
                res_d = '0;
                cmp_d = 1'b0;
            end
        endcase
        // Set-less-than and branch compares return the flag zero-extended.
        if (op inside {OP_SLT, OP_SLTU, OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU}) begin
            res_d = {{(XLEN-1){1'b0}}, cmp_d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result  <= '0;
            Compare <= 1'b0;
        end else begin
            Result  <= res_d;
            Compare <= cmp_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, reset behaviour and randomized
// back-to-back operations against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] InA;
    logic [31:0] InB;
    logic [3:0]  Op;
    logic [31:0] Result;
    logic        Compare;

    int n_checks = 0;
    int n_pass   = 0;

    alu #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .InA     (InA),
        .InB     (InB),
        .Op      (Op),
        .Result  (Result),
        .Compare (Compare)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {compare, result} computed from the opcode table semantics.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int signed   sa;
        int signed   sb;
        int          sh;
        logic [31:0] r;
        logic        c;
        sa = a;
        sb = b;
        sh = int'(b % 32);
        r  = 32'd0;
        c  = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  c = (sa < sb);
            4'd6:  c = (a < b);
            4'd7:  r = a << sh;
            4'd8:  r = a >> sh;
            4'd9:  r = sa >>> sh;
            4'd10: c = (a == b);
            4'd11: c = (a != b);
            4'd12: c = (sa < sb);
            4'd13: c = (sa >= sb);
            4'd14: c = (a < b);
            default: c = (a >= b);
        endcase
        if (op >= 4'd10 || op == 4'd5 || op == 4'd6) r = c ? 32'd1 : 32'd0;
        return {c, r};
    endfunction

    // Called at posedge+1: drive, wait one edge, check. Consecutive calls give
    // a new operation every cycle.
    task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        logic [32:0] e;
        Op  = op;
        InA = a;
        InB = b;
        e   = model(op, a, b);
        @(posedge clk);
        #1;
        chk({tag, ".res"}, Result, e[31:0]);
        chk({tag, ".cmp"}, {31'd0, Compare}, {31'd0, e[32]});
    endtask

    // Same as step but with an explicitly stated expected value.
    task automatic step_exp(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic ec);
        Op  = op;
        InA = a;
        InB = b;
        @(posedge clk);
        #1;
        chk({tag, ".res"}, Result, er);
        chk({tag, ".cmp"}, {31'd0, Compare}, {31'd0, ec});
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = $urandom_range(0, 40);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] held;
        rst = 1'b1;
        Op  = 4'd0;
        InA = 32'd0;
        InB = 32'd0;
        #1;
        chk("reset.res", Result, 32'd0);
        chk("reset.cmp", {31'd0, Compare}, 32'd0);

        // Release mid-cycle; the first edge with rst low loads normally.
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_exp("add", 4'd0, 32'd15, 32'd10, 32'd25, 1'b0);
        step_exp("sub", 4'd1, 32'd25, 32'd10, 32'd15, 1'b0);
        step_exp("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        step_exp("and", 4'd2, 32'hA, 32'h3, 32'h2, 1'b0);
        step_exp("or", 4'd3, 32'hA, 32'h5, 32'hF, 1'b0);
        step_exp("xor", 4'd4, 32'hF, 32'hF, 32'h0, 1'b0);
        step_exp("slt_neg", 4'd5, 32'hFFFF_FFFB, 32'd10, 32'd1, 1'b1);
        step_exp("sltu_neg", 4'd6, 32'hFFFF_FFFB, 32'd10, 32'd0, 1'b0);
        step_exp("sltu", 4'd6, 32'd5, 32'd10, 32'd1, 1'b1);
        step_exp("slt_eq", 4'd5, 32'd10, 32'd10, 32'd0, 1'b0);
        step_exp("sll", 4'd7, 32'h1, 32'h21, 32'h2, 1'b0);
        step_exp("srl", 4'd8, 32'h8000_0000, 32'd31, 32'h1, 1'b0);
        step_exp("sra", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
        step_exp("eq", 4'd10, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b0);
        step_exp("ne", 4'd11, 32'hFFFF_FFFF, 32'h1, 32'd1, 1'b1);
        step_exp("lt", 4'd12, 32'hFFFF_FFFF, 32'h1, 32'd1, 1'b1);
        step_exp("ge", 4'd13, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b0);
        step_exp("ltu", 4'd14, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b0);
        step_exp("geu", 4'd15, 32'hFFFF_FFFF, 32'h1, 32'd1, 1'b1);
        step_exp("lt_min_max", 4'd12, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b1);
        step_exp("ltu_min_max", 4'd14, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0);
        step_exp("eq_true", 4'd10, 32'h1234_5678, 32'h1234_5678, 32'd1, 1'b1);

        // Input changes between edges must not reach the outputs.
        step_exp("hold_pre", 4'd0, 32'd100, 32'd23, 32'd123, 1'b0);
        held = Result;
        Op  = 4'd15;
        InA = 32'd7;
        InB = 32'd3;
        #3;
        chk("hold.res", Result, 32'd123);
        chk("hold.cmp", {31'd0, Compare}, 32'd0);

        // Async reset with nonzero outputs: clears before any clock edge.
        @(posedge clk);
        #1;
        chk("pre_rst.cmp", {31'd0, Compare}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst.res", Result, 32'd0);
        chk("async_rst.cmp", {31'd0, Compare}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold.res", Result, 32'd0);
        rst = 1'b0;
        step_exp("post_rst", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
        if (held == 32'd0) chk("hold_sample", held, 32'd123);

        // Randomized back-to-back stream, one new op per cycle.
        for (int i = 0; i < 400; i++) begin
            a = rnd_operand();
            b = ($urandom_range(0, 7) == 0) ? a : rnd_operand();
            step("rand", 4'($urandom_range(0, 15)), a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
